fp_addsub_zero_detect: RTL and testbench

//   Pipelined, parametrised exact-zero detector for the FP add/sub datapath.
//   - Flags, two cycles after acceptance, whether A +/- B is exactly zero, and

---
 rtl/fp_addsub_zero_detect.sv | 184 ++++++++++++++++++
 tb/tb_fp_addsub_zero_detect.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_zero_detect.sv
// ---------------------------------------------------------------------------
// FpAddSubZeroDetect (module fp_addsub_zero_detect)
//
// Purpose
//   Pipelined exact-zero detector that sits beside the exponent comparator in
//   the stallable pre-alignment stage of the FP add/sub datapath. It reports,
//   two cycles after an operand pair is accepted, whether A +/- B is exactly
//   zero. It also reports the IEEE-754 sign that zero must carry for the
//   selected rounding mode. Inf/NaN operands never produce a zero flag.
//
// Parameters
//   EW  exponent field width (8 single, 11 double)
//   SW  stored significand width without hidden bit (23 single, 52 double)
//   W   derived operand width 1+EW+SW (local, not overridable)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active high
//   i_in_valid    operand pair / op / rounding mode valid this cycle
//   o_in_ready    block accepts an operand pair this cycle
//   i_op_a        operand A {sign, exponent, significand}
//   i_op_b        operand B {sign, exponent, significand}
//   i_arit_op     0 = add, 1 = subtract
//   i_rmode       00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
//   o_out_valid   result flags valid
//   i_out_ready   downstream consumes the result this cycle
//   o_zero        exact result is +0 or -0
//   o_zero_sign   sign of that zero (0 when o_zero is 0)
//   o_cancel      equal magnitudes under effective subtraction
//   o_special     either operand has an all-ones exponent (Inf/NaN)
// ---------------------------------------------------------------------------
module fp_addsub_zero_detect #(
    parameter  int EW = 8,
    parameter  int SW = 23,
    localparam int W  = 1 + EW + SW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [W-1:0] i_op_a,
    input  logic [W-1:0] i_op_b,
    input  logic         i_arit_op,
    input  logic [1:0]   i_rmode,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic         o_zero,
    output logic         o_zero_sign,
    output logic         o_cancel,
    output logic         o_special
);

    // Round-toward-negative-infinity is the only mode in which an exact
    // cancellation yields -0; every other mode gives +0.
    localparam logic [1:0] RMODE_RTN = 2'b11;

    // Stage occupancy flags.
    logic       r_v1;
    logic       r_v2;

    // S1 registered pre-computation.
    logic       r_magEq;
    logic       r_aZero;
    logic       r_bZero;
    logic       r_spec;
    logic       r_effSub;
    logic       r_signA;
    logic [1:0] r_rmode;

    // Handshake / stage-advance controls.
    logic       w_s2Load;
    logic       w_s1Load;
    logic       w_accept;

    // S1 combinational inputs.
    logic       w_magEq;
    logic       w_aZero;
    logic       w_bZero;
    logic       w_spec;
    logic       w_effSub;

    // S2 combinational results derived from the S1 registers.
    logic       w_cancel;
    logic       w_zero;
    logic       w_zeroSign;

    // Stage advance is the classic two-entry elastic pipeline: the output
    // stage refills whenever it is empty or being drained, and the first
    // stage refills whenever it is empty or can pass its entry forward.
    // in_ready deliberately depends only on the valid flags and out_ready,
    // so there is no combinational loop through in_valid upstream.
    always_comb begin
        w_s2Load   = ~r_v2 | i_out_ready;
        w_s1Load   = ~r_v1 | w_s2Load;
        o_in_ready = ~r_v1 | ~r_v2 | i_out_ready;
        w_accept   = i_in_valid & o_in_ready;
    end

    // First-stage operand inspection. Comparing the whole magnitude field
    // (exponent plus stored significand) makes subnormals compare exactly,
    // and a nonzero significand with a zero exponent is correctly treated as
    // nonzero. The effective operation folds both signs with the requested
    // op, so add of opposite signs and subtract of equal signs look alike.
    always_comb begin
        w_magEq  = (i_op_a[W-2:0] == i_op_b[W-2:0]);
        w_aZero  = ~|i_op_a[W-2:0];
        w_bZero  = ~|i_op_b[W-2:0];
        w_spec   = (&i_op_a[W-2:SW]) | (&i_op_b[W-2:SW]);
        w_effSub = i_op_a[W-1] ^ i_op_b[W-1] ^ i_arit_op;
    end

    // S1 register. The valid flag follows the handshake whenever the stage
    // is allowed to load; payload is only captured on a real acceptance so a
    // stalled entry keeps its contents bit-exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_magEq  <= 1'b0;
            r_aZero  <= 1'b0;
            r_bZero  <= 1'b0;
            r_spec   <= 1'b0;
            r_effSub <= 1'b0;
            r_signA  <= 1'b0;
            r_rmode  <= 2'b00;
        end else if (w_s1Load) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_magEq  <= w_magEq;
                r_aZero  <= w_aZero;
                r_bZero  <= w_bZero;
                r_spec   <= w_spec;
                r_effSub <= w_effSub;
                r_signA  <= i_op_a[W-1];
                r_rmode  <= i_rmode;
            end
        end
    end

    // Second-stage decision. An Inf or NaN on either side suppresses both
    // the cancel and the zero flag, which also covers Inf - Inf. Two zero
    // operands always sum to zero even without effective subtraction. For
    // the sign: a true addition of two zeros keeps their common sign, while
    // any cancellation takes -0 only under round toward negative infinity.
    always_comb begin
        w_cancel   = r_magEq & r_effSub & ~r_spec;
        w_zero     = ~r_spec & (w_cancel | (r_aZero & r_bZero));
        w_zeroSign = 1'b0;
        if (w_zero) begin
            if (~r_effSub) begin
                w_zeroSign = r_signA;
            end else begin
                w_zeroSign = (r_rmode == RMODE_RTN);
            end
        end
    end

    // S2 register holding the visible flags. A bubble moving in only clears
    // the valid flag; the flag outputs keep their last values, which nobody
    // may interpret while out_valid is low. Reset clears everything at once
    // so out_valid falls as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2        <= 1'b0;
            o_zero      <= 1'b0;
            o_zero_sign <= 1'b0;
            o_cancel    <= 1'b0;
            o_special   <= 1'b0;
        end else if (w_s2Load) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                o_zero      <= w_zero;
                o_zero_sign <= w_zeroSign;
                o_cancel    <= w_cancel;
                o_special   <= r_spec;
            end
        end
    end

    // The output stage's occupancy is the result-valid indication.
    always_comb begin
        o_out_valid = r_v2;
    end

endmodule

// File: tb/tb_fp_addsub_zero_detect.sv
// ---------------------------------------------------------------------------
// Self-checking bench for fp_addsub_zero_detect (EW=8, SW=23).
// A reference model computes the exact-zero outcome from IEEE-754 rules, and
// a queue of accepted operations with their acceptance cycle predicts
// in_ready, out_valid and the flags seen at the head of the pipeline.
// ---------------------------------------------------------------------------
module tb_fp_addsub_zero_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        aritOp;
    logic [1:0]  rmode;
    logic        outValid;
    logic        outReady;
    logic        zero;
    logic        zeroSign;
    logic        cancel;
    logic        special;

    typedef struct {
        logic        zero;
        logic        zeroSign;
        logic        cancel;
        logic        special;
        int unsigned acc;
    } expect_t;

    expect_t     sb[$];
    int unsigned cycle = 0;
    int          nVectors = 0;
    int          nMiscompares = 0;

    fp_addsub_zero_detect #(.EW(8), .SW(23)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_op_a      (opA),
        .i_op_b      (opB),
        .i_arit_op   (aritOp),
        .i_rmode     (rmode),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_zero      (zero),
        .o_zero_sign (zeroSign),
        .o_cancel    (cancel),
        .o_special   (special)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Cycle index used to time-stamp acceptances.
    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something wedges the run entirely.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    // IEEE-754 exact-zero reference: finite operands give an exact zero when
    // the value b' = (op ? -b : b) is the exact negation of a, or when both
    // are zeros. The sum of two like-signed zeros keeps that sign; any exact
    // cancellation gives -0 only when rounding toward -inf.
    function automatic expect_t refModel(input logic [31:0] a, input logic [31:0] b,
                                         input logic op, input logic [1:0] rm);
        expect_t     e;
        logic        isSpecial;
        logic        signBEff;
        logic        opposite;
        logic        sameMag;
        logic        bothZero;
        isSpecial  = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
        signBEff   = b[31] ^ op;
        opposite   = (a[31] != signBEff);
        sameMag    = (a[30:0] == b[30:0]);
        bothZero   = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        e.special  = isSpecial;
        e.cancel   = !isSpecial && sameMag && opposite;
        e.zero     = !isSpecial && ((sameMag && opposite) || bothZero);
        e.zeroSign = 1'b0;
        if (e.zero) e.zeroSign = opposite ? (rm == 2'b11) : a[31];
        e.acc      = 0;
        return e;
    endfunction

    // Operand generator biased toward zeros, specials and subnormals.
    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v = {v[31], 31'd0};
            1: v = {v[31], 8'hFF, (v[0] ? 23'd0 : v[22:0])};
            2: v = {v[31], 8'h00, 19'd0, v[3:0]};
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic randomInputs();
        opA = randOperand();
        case ($urandom_range(0, 3))
            0: opB = opA;
            1: opB = opA ^ 32'h8000_0000;
            default: opB = randOperand();
        endcase
        aritOp = 1'($urandom_range(0, 1));
        rmode  = 2'($urandom_range(0, 3));
    endtask

    // Called at the falling edge: predicts this cycle's in_ready/out_valid
    // and the head result, then books the transfers implied by the inputs.
    task automatic observe(output logic expReady, output logic expValid, output expect_t head);
        expect_t e;
        expReady = (sb.size() < 2) || outReady;
        expValid = (sb.size() > 0) && (cycle >= sb[0].acc + 2);
        head     = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        if (sb.size() > 0) head = sb[0];
        if (expValid && outReady) void'(sb.pop_front());
        if (inValid && expReady) begin
            e     = refModel(opA, opB, aritOp, rmode);
            e.acc = cycle;
            sb.push_back(e);
        end
    endtask

    // Drives one isolated operation and waits for its result (no checks).
    task automatic runSingle(input logic [31:0] a, input logic [31:0] b, input logic op,
                             input logic [1:0] rm, output logic [3:0] got, output int lat);
        logic found;
        opA = a; opB = b; aritOp = op; rmode = rm;
        inValid = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 0; found = 1'b0; got = 4'bxxxx;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (outValid === 1'b1) begin
                got   = {zero, zeroSign, cancel, special};
                found = 1'b1;
            end
        end
        if (!found) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b1; outReady = 1'b1;
        opA = 32'h3F80_0000; opB = 32'h3F80_0000; aritOp = 1'b1; rmode = 2'b00;
        #3;
        nVectors++;
        if (outValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL reset_out_valid got=%b want=0", outValid); end
        nVectors++;
        if ({zero, zeroSign, cancel, special} !== 4'b0000) begin
            nMiscompares++; $display("[TB] FAIL reset_flags got=%b want=0000", {zero, zeroSign, cancel, special});
        end
        nVectors++;
        if (inReady !== 1'b1) begin nMiscompares++; $display("[TB] FAIL reset_in_ready got=%b want=1", inReady); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        inValid = 1'b0; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nVectors++;
            if (outValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL post_reset_out_valid i=%0d got=%b want=0", i, outValid); end
            nVectors++;
            if (inReady !== 1'b1) begin nMiscompares++; $display("[TB] FAIL post_reset_in_ready i=%0d got=%b want=1", i, inReady); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[9];
        logic [31:0] vb[9];
        logic        vop[9];
        logic [1:0]  vrm[9];
        logic [3:0]  want[9];
        logic [3:0]  got;
        int          lat;
        // want = {zero, zero_sign, cancel, special}
        va[0]=32'h3F80_0000; vb[0]=32'h3F80_0000; vop[0]=1; vrm[0]=2'b00; want[0]=4'b1010;
        va[1]=32'h3F80_0000; vb[1]=32'hBF80_0000; vop[1]=0; vrm[1]=2'b11; want[1]=4'b1110;
        va[2]=32'h8000_0000; vb[2]=32'h8000_0000; vop[2]=0; vrm[2]=2'b00; want[2]=4'b1100;
        va[3]=32'h8000_0000; vb[3]=32'h8000_0000; vop[3]=1; vrm[3]=2'b00; want[3]=4'b1010;
        va[4]=32'h7F80_0000; vb[4]=32'h7F80_0000; vop[4]=1; vrm[4]=2'b00; want[4]=4'b0001;
        va[5]=32'h0000_0001; vb[5]=32'h0000_0000; vop[5]=0; vrm[5]=2'b00; want[5]=4'b0000;
        va[6]=32'h7FC0_0000; vb[6]=32'h7FC0_0000; vop[6]=1; vrm[6]=2'b11; want[6]=4'b0001;
        va[7]=32'h0000_0005; vb[7]=32'h0000_0005; vop[7]=1; vrm[7]=2'b11; want[7]=4'b1110;
        va[8]=32'h0000_0000; vb[8]=32'h8000_0000; vop[8]=0; vrm[8]=2'b10; want[8]=4'b1010;
        for (int i = 0; i < 9; i++) begin
            runSingle(va[i], vb[i], vop[i], vrm[i], got, lat);
            nVectors++;
            if (lat !== 2) begin nMiscompares++; $display("[TB] FAIL directed_latency #%0d got=%0d want=2", i, lat); end
            nVectors++;
            if (got !== want[i]) begin
                nMiscompares++;
                $display("[TB] FAIL directed_flags #%0d A=%h B=%h op=%b rm=%b got=%b want=%b",
                         i, va[i], vb[i], vop[i], vrm[i], got, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic    eR, eV;
        expect_t h;
        int      received = 0;
        inValid = 1'b1; outReady = 1'b1;
        for (int k = 0; k < 30; k++) begin
            inValid = (k < 24);
            randomInputs();
            @(negedge clk);
            observe(eR, eV, h);
            nVectors++;
            if (inReady !== 1'b1) begin nMiscompares++; $display("[TB] FAIL b2b_in_ready cyc=%0d got=%b want=1", cycle, inReady); end
            nVectors++;
            if (outValid !== eV) begin nMiscompares++; $display("[TB] FAIL b2b_out_valid cyc=%0d got=%b want=%b", cycle, outValid, eV); end
            if (eV) begin
                received++;
                nVectors++;
                if ({zero, zeroSign, cancel, special} !== {h.zero, h.zeroSign, h.cancel, h.special}) begin
                    nMiscompares++;
                    $display("[TB] FAIL b2b_flags cyc=%0d got=%b want=%b", cycle,
                             {zero, zeroSign, cancel, special}, {h.zero, h.zeroSign, h.cancel, h.special});
                end
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        nVectors++;
        if (received !== 24 || sb.size() !== 0) begin
            nMiscompares++; $display("[TB] FAIL b2b_count got=%0d want=24 left=%0d", received, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_stall();
        logic    eR, eV;
        expect_t h;
        int      idx = 0;
        int      received = 0;
        logic    sawDrop = 1'b0;
        int      k = 0;
        while ((idx < 8 || sb.size() != 0) && k < 60) begin
            outReady = !(k >= 3 && k <= 5);
            inValid  = (idx < 8);
            if (eR || k == 0) randomInputs();
            @(negedge clk);
            observe(eR, eV, h);
            nVectors++;
            if (inReady !== eR) begin nMiscompares++; $display("[TB] FAIL stall_in_ready k=%0d got=%b want=%b", k, inReady, eR); end
            nVectors++;
            if (outValid !== eV) begin nMiscompares++; $display("[TB] FAIL stall_out_valid k=%0d got=%b want=%b", k, outValid, eV); end
            if (eV) begin
                nVectors++;
                if ({zero, zeroSign, cancel, special} !== {h.zero, h.zeroSign, h.cancel, h.special}) begin
                    nMiscompares++;
                    $display("[TB] FAIL stall_flags k=%0d got=%b want=%b", k,
                             {zero, zeroSign, cancel, special}, {h.zero, h.zeroSign, h.cancel, h.special});
                end
                if (outReady) received++;
            end
            if (!eR) sawDrop = 1'b1;
            if (inValid && eR) idx++;
            @(posedge clk); #1;
            k++;
        end
        inValid = 1'b0; outReady = 1'b1;
        nVectors++;
        if (received !== 8) begin nMiscompares++; $display("[TB] FAIL stall_count got=%0d want=8", received); end
        nVectors++;
        if (sawDrop !== 1'b1) begin nMiscompares++; $display("[TB] FAIL stall_ready_drop got=%b want=1", sawDrop); end
        sb.delete();
    endtask

    task automatic test_random_stream(input int nCycles);
        logic    eR, eV;
        expect_t h;
        int      k = 0;
        eR = 1'b1;
        while (k < nCycles || (sb.size() != 0 && k < nCycles + 40)) begin
            inValid  = (k < nCycles) && ($urandom_range(0, 99) < 70);
            outReady = (k >= nCycles) || ($urandom_range(0, 99) < 65);
            randomInputs();
            @(negedge clk);
            observe(eR, eV, h);
            nVectors++;
            if (inReady !== eR) begin nMiscompares++; $display("[TB] FAIL rnd_in_ready cyc=%0d got=%b want=%b", cycle, inReady, eR); end
            nVectors++;
            if (outValid !== eV) begin nMiscompares++; $display("[TB] FAIL rnd_out_valid cyc=%0d got=%b want=%b", cycle, outValid, eV); end
            if (eV) begin
                nVectors++;
                if ({zero, zeroSign, cancel, special} !== {h.zero, h.zeroSign, h.cancel, h.special}) begin
                    nMiscompares++;
                    $display("[TB] FAIL rnd_flags cyc=%0d got=%b want=%b", cycle,
                             {zero, zeroSign, cancel, special}, {h.zero, h.zeroSign, h.cancel, h.special});
                end
            end
            @(posedge clk); #1;
            k++;
        end
        inValid = 1'b0; outReady = 1'b1;
        nVectors++;
        if (sb.size() !== 0) begin nMiscompares++; $display("[TB] FAIL rnd_drain got=%0d want=0 pending", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_midflight();
        logic    eR, eV;
        expect_t h;
        int      k;
        outReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            inValid = 1'b1;
            opA = 32'h4040_0000; opB = 32'h4040_0000; aritOp = 1'b1; rmode = 2'b00;
            @(negedge clk);
            observe(eR, eV, h);
            @(posedge clk); #1;
        end
        inValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        nVectors++;
        if (outValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midrst_async_out_valid got=%b want=0", outValid); end
        nVectors++;
        if ({zero, zeroSign, cancel, special} !== 4'b0000) begin
            nMiscompares++; $display("[TB] FAIL midrst_flags got=%b want=0000", {zero, zeroSign, cancel, special});
        end
        sb.delete();
        @(posedge clk); #1;
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0; rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            observe(eR, eV, h);
            nVectors++;
            if (outValid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL midrst_quiet i=%0d got=%b want=0", i, outValid); end
        end
        @(posedge clk); #1;
        inValid = 1'b1;
        opA = 32'hC120_0000; opB = 32'h4120_0000; aritOp = 1'b0; rmode = 2'b11;
        k = 0;
        while ((k == 0 || sb.size() != 0) && k < 12) begin
            if (k > 0) inValid = 1'b0;
            @(negedge clk);
            observe(eR, eV, h);
            nVectors++;
            if (outValid !== eV) begin nMiscompares++; $display("[TB] FAIL midrst_new_valid k=%0d got=%b want=%b", k, outValid, eV); end
            if (eV) begin
                nVectors++;
                if ({zero, zeroSign, cancel, special} !== {h.zero, h.zeroSign, h.cancel, h.special}) begin
                    nMiscompares++;
                    $display("[TB] FAIL midrst_new_flags got=%b want=%b",
                             {zero, zeroSign, cancel, special}, {h.zero, h.zeroSign, h.cancel, h.special});
                end
            end
            @(posedge clk); #1;
            k++;
        end
        inValid = 1'b0;
        nVectors++;
        if (sb.size() !== 0) begin nMiscompares++; $display("[TB] FAIL midrst_new_drain got=%0d want=0 pending", sb.size()); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random_stream(300);
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
